stage2_k_unpack: RTL and testbench

STAGE2_K_UNPACK -- requirements
Module: stage2_k_unpack

---
 rtl/stage2_k_unpack_pkg.sv | 55 +++++
 rtl/stage2_k_field_split.sv | 22 ++
 rtl/stage2_k_unpack.sv | 145 ++++++++++++++
 tb/tb_stage2_k_unpack.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage2_k_unpack_pkg.sv
// Shared layout definitions for the stage-2 category-k message: byte offsets,
// defaults, FSM state encoding and the decoded field bundle.
package stage2_k_unpack_pkg;

   localparam int         MSG_BYTES_DEF  = 35;
   localparam logic [7:0] K_CATEGORY_DEF = 8'h6B;
   localparam int         SHIFT_W        = 8 * MSG_BYTES_DEF;

   // byte offsets from the start of the packed message (byte 0 = first on the wire)
   localparam int OFF_PID    = 0;
   localparam int OFF_CAT    = 1;
   localparam int OFF_TYPE   = 2;
   localparam int OFF_RSV0   = 3;
   localparam int OFF_SYM    = 4;
   localparam int OFF_RSV1   = 9;
   localparam int OFF_EXP    = 10;
   localparam int OFF_SDEN   = 13;
   localparam int OFF_SPRICE = 14;
   localparam int OFF_PDEN   = 18;
   localparam int OFF_BPRICE = 19;
   localparam int OFF_BSIZE  = 23;
   localparam int OFF_OPRICE = 27;
   localparam int OFF_OSIZE  = 31;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]  participant_id;
      logic [7:0]  msg_category;
      logic [7:0]  msg_type;
      logic [39:0] security_symbol;
      logic [23:0] expiration_block;
      logic [7:0]  strike_den_code;
      logic [31:0] strike_price;
      logic [7:0]  premium_den_code;
      logic [31:0] bid_price;
      logic [31:0] bid_size;
      logic [31:0] offer_price;
      logic [31:0] offer_size;
   } k_fields_t;

   // MSB position of a byte offset once the whole message sits in the shift register
   function automatic int msb_of(input int off);
      return SHIFT_W - 1 - 8 * off;
   endfunction

   function automatic logic rsvd_nonzero(input logic [SHIFT_W-1:0] s);
      return (|s[SHIFT_W-1-8*OFF_RSV0 -: 8]) | (|s[SHIFT_W-1-8*OFF_RSV1 -: 8]);
   endfunction

endpackage

// File: rtl/stage2_k_field_split.sv
// Combinational slice of the assembled 280-bit message into its named fields.
module stage2_k_field_split
   import stage2_k_unpack_pkg::*;
(
   input  logic [SHIFT_W-1:0] shift_i,
   output k_fields_t          fields_o
);

   assign fields_o.participant_id   = shift_i[msb_of(OFF_PID)    -: 8];
   assign fields_o.msg_category     = shift_i[msb_of(OFF_CAT)    -: 8];
   assign fields_o.msg_type         = shift_i[msb_of(OFF_TYPE)   -: 8];
   assign fields_o.security_symbol  = shift_i[msb_of(OFF_SYM)    -: 40];
   assign fields_o.expiration_block = shift_i[msb_of(OFF_EXP)    -: 24];
   assign fields_o.strike_den_code  = shift_i[msb_of(OFF_SDEN)   -: 8];
   assign fields_o.strike_price     = shift_i[msb_of(OFF_SPRICE) -: 32];
   assign fields_o.premium_den_code = shift_i[msb_of(OFF_PDEN)   -: 8];
   assign fields_o.bid_price        = shift_i[msb_of(OFF_BPRICE) -: 32];
   assign fields_o.bid_size         = shift_i[msb_of(OFF_BSIZE)  -: 32];
   assign fields_o.offer_price      = shift_i[msb_of(OFF_OPRICE) -: 32];
   assign fields_o.offer_size       = shift_i[msb_of(OFF_OSIZE)  -: 32];

endmodule

// File: rtl/stage2_k_unpack.sv
// Stage-2 category-k unpacker: collects a byte stream into a message register,
// screens the category byte and presents the decoded fields until consumed.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for an in_sof beat; other beats are ignored
//   ST_COLLECT | shifting message bytes in; sof restarts, bad category drops
//   ST_HOLD    | full message presented on out_valid; input back-pressured
module stage2_k_unpack
   import stage2_k_unpack_pkg::*;
#(
   parameter int         MSG_BYTES  = MSG_BYTES_DEF,
   parameter logic [7:0] K_CATEGORY = K_CATEGORY_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  participant_id,
   output logic [7:0]  msg_category,
   output logic [7:0]  msg_type,
   output logic [39:0] security_symbol,
   output logic [23:0] expiration_block,
   output logic [7:0]  strike_den_code,
   output logic [31:0] strike_price,
   output logic [7:0]  premium_den_code,
   output logic [31:0] bid_price,
   output logic [31:0] bid_size,
   output logic [31:0] offer_price,
   output logic [31:0] offer_size,
   output logic        rsvd_err,
   output logic        drop_pulse
);

   localparam logic [5:0] LAST_CNT = 6'(MSG_BYTES - 1);

   state_e             state_q;
   logic [5:0]         count_q;
   logic [SHIFT_W-1:0] shift_q;
   logic               out_valid_q;
   logic               rsvd_err_q;
   logic               drop_q;
   logic               in_ready_q;

   logic               accept;
   logic [SHIFT_W-1:0] shift_d;
   logic [SHIFT_W-1:0] shift_sof;
   k_fields_t          fields;

   // in_ready is registered, so acceptance is judged on the registered copy
   assign accept    = in_valid & in_ready_q;
   assign shift_d   = {shift_q[SHIFT_W-9:0], in_data};
   assign shift_sof = {{(SHIFT_W-8){1'b0}}, in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         rsvd_err_q  <= 1'b0;
         drop_q      <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept && in_sof) begin
                  shift_q <= shift_sof;
                  count_q <= 6'd1;
                  state_q <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (in_sof) begin
                     drop_q  <= 1'b1;
                     shift_q <= shift_sof;
                     count_q <= 6'd1;
                  end else if (count_q == 6'd1 && in_data != K_CATEGORY) begin
                     drop_q  <= 1'b1;
                     count_q <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     shift_q <= shift_d;
                     count_q <= count_q + 6'd1;
                     if (count_q == LAST_CNT) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        rsvd_err_q  <= rsvd_nonzero(shift_d);
                     end
                  end
               end
            end
            ST_HOLD: begin
               in_ready_q <= 1'b0;
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  count_q     <= '0;
                  out_valid_q <= 1'b0;
                  rsvd_err_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               count_q     <= '0;
               out_valid_q <= 1'b0;
               rsvd_err_q  <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   stage2_k_field_split u_split (
      .shift_i  (shift_q),
      .fields_o (fields)
   );

   assign in_ready         = in_ready_q;
   assign out_valid        = out_valid_q;
   assign rsvd_err         = rsvd_err_q;
   assign drop_pulse       = drop_q;
   assign participant_id   = fields.participant_id;
   assign msg_category     = fields.msg_category;
   assign msg_type         = fields.msg_type;
   assign security_symbol  = fields.security_symbol;
   assign expiration_block = fields.expiration_block;
   assign strike_den_code  = fields.strike_den_code;
   assign strike_price     = fields.strike_price;
   assign premium_den_code = fields.premium_den_code;
   assign bid_price        = fields.bid_price;
   assign bid_size         = fields.bid_size;
   assign offer_price      = fields.offer_price;
   assign offer_size       = fields.offer_size;

endmodule

// File: tb/tb_stage2_k_unpack.sv
// Directed bench for stage2_k_unpack: packs hand-chosen field values into byte
// streams and compares the decoded outputs against those same values.
module tb_stage2_k_unpack;

   // wire order of a category-k message, byte 0 in the top bits
   typedef struct packed {
      logic [7:0]  pid;
      logic [7:0]  cat;
      logic [7:0]  typ;
      logic [7:0]  rsv3;
      logic [39:0] sym;
      logic [7:0]  rsv9;
      logic [23:0] expb;
      logic [7:0]  sden;
      logic [31:0] sprice;
      logic [7:0]  pden;
      logic [31:0] bprice;
      logic [31:0] bsize;
      logic [31:0] oprice;
      logic [31:0] osize;
   } msg_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  participant_id, msg_category, msg_type;
   logic [39:0] security_symbol;
   logic [23:0] expiration_block;
   logic [7:0]  strike_den_code, premium_den_code;
   logic [31:0] strike_price, bid_price, bid_size, offer_price, offer_size;
   logic        rsvd_err;
   logic        drop_pulse;

   int n_chk = 0;
   int n_bad = 0;
   int ov_cnt = 0;
   int drop_cnt = 0;
   int ov_mark, drop_mark;

   msg_t msg_a, msg_b, msg_c, msg_d;

   always #5 clk = ~clk;

   stage2_k_unpack dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_sof           (in_sof),
      .in_ready         (in_ready),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .participant_id   (participant_id),
      .msg_category     (msg_category),
      .msg_type         (msg_type),
      .security_symbol  (security_symbol),
      .expiration_block (expiration_block),
      .strike_den_code  (strike_den_code),
      .strike_price     (strike_price),
      .premium_den_code (premium_den_code),
      .bid_price        (bid_price),
      .bid_size         (bid_size),
      .offer_price      (offer_price),
      .offer_size       (offer_size),
      .rsvd_err         (rsvd_err),
      .drop_pulse       (drop_pulse)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid)  ov_cnt++;
         if (drop_pulse) drop_cnt++;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // present one beat and hold it until an edge where in_ready was high
   task automatic send_byte(input logic [7:0] b, input logic sof);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      in_sof   = sof;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_chk++;
         n_bad++;
         $display("FAIL accept_timeout: byte %h never accepted", b);
      end
   endtask

   task automatic send_msg(input msg_t m, input bit toggle, input int nbytes);
      logic [279:0] v;
      v = m;
      for (int i = 0; i < nbytes; i++) begin
         send_byte(v[279-8*i -: 8], i == 0);
         if (toggle && i != nbytes - 1) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic check_fields(input string pfx, input msg_t m, input logic exp_rsvd);
      check_val({pfx, ".out_valid"}, 64'(out_valid), 64'd1);
      check_val({pfx, ".pid"},    64'(participant_id),   64'(m.pid));
      check_val({pfx, ".cat"},    64'(msg_category),     64'(m.cat));
      check_val({pfx, ".type"},   64'(msg_type),         64'(m.typ));
      check_val({pfx, ".sym"},    64'(security_symbol),  64'(m.sym));
      check_val({pfx, ".exp"},    64'(expiration_block), 64'(m.expb));
      check_val({pfx, ".sden"},   64'(strike_den_code),  64'(m.sden));
      check_val({pfx, ".sprice"}, 64'(strike_price),     64'(m.sprice));
      check_val({pfx, ".pden"},   64'(premium_den_code), 64'(m.pden));
      check_val({pfx, ".bprice"}, 64'(bid_price),        64'(m.bprice));
      check_val({pfx, ".bsize"},  64'(bid_size),         64'(m.bsize));
      check_val({pfx, ".oprice"}, 64'(offer_price),      64'(m.oprice));
      check_val({pfx, ".osize"},  64'(offer_size),       64'(m.osize));
      check_val({pfx, ".rsvd"},   64'(rsvd_err),         64'(exp_rsvd));
      check_val({pfx, ".in_rdy_hold"}, 64'(in_ready),    64'd0);
   endtask

   // with out_ready high the handshake happens on the next edge
   task automatic close_msg(input string pfx);
      @(posedge clk);
      #1;
      check_val({pfx, ".ov_clr"},  64'(out_valid), 64'd0);
      check_val({pfx, ".rdy_ret"}, 64'(in_ready),  64'd1);
      check_val({pfx, ".rsvd_clr"}, 64'(rsvd_err), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      msg_a = '{pid:8'h41, cat:8'h6B, typ:8'h02, rsv3:8'h00, sym:40'h41_42_43_44_45,
                rsv9:8'h00, expb:24'h0A_1B_2C, sden:8'h02, sprice:32'h0001_86A0,
                pden:8'h03, bprice:32'h0000_1388, bsize:32'h0000_0064,
                oprice:32'h0000_13EC, osize:32'h0000_00C8};
      msg_b = '{pid:8'h55, cat:8'h6B, typ:8'h07, rsv3:8'h00, sym:40'h58_59_5A_31_32,
                rsv9:8'h00, expb:24'hFF_00_11, sden:8'h04, sprice:32'hDEAD_BEEF,
                pden:8'h01, bprice:32'h1234_5678, bsize:32'h0000_0001,
                oprice:32'h8765_4321, osize:32'hFFFF_FFFE};
      msg_c = '{pid:8'h42, cat:8'h6B, typ:8'h01, rsv3:8'h00, sym:40'h4D_53_46_54_20,
                rsv9:8'h00, expb:24'h12_34_56, sden:8'h00, sprice:32'h0000_0000,
                pden:8'hA5, bprice:32'h0000_2710, bsize:32'h0000_0032,
                oprice:32'h0000_2774, osize:32'h0000_0019};
      msg_d = msg_a;
      msg_d.rsv9 = 8'hFF;

      // reset values, then in_ready rises on the first clock after release
      #2;
      check_val("rst.in_ready",  64'(in_ready),   64'd0);
      check_val("rst.out_valid", 64'(out_valid),  64'd0);
      check_val("rst.drop",      64'(drop_pulse), 64'd0);
      check_val("rst.rsvd",      64'(rsvd_err),   64'd0);
      #10 rst_n = 1'b1;
      #1;
      check_val("rel.in_ready_pre", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check_val("rel.in_ready", 64'(in_ready), 64'd1);

      // continuous valid message
      ov_mark = ov_cnt;
      send_msg(msg_a, 1'b0, 35);
      check_val("a.no_early_ov", 64'(ov_cnt), 64'(ov_mark));
      check_fields("a", msg_a, 1'b0);
      close_msg("a");
      check_val("a.ov_once", 64'(ov_cnt - ov_mark), 64'd1);

      // same message with in_valid toggling
      ov_mark = ov_cnt;
      send_msg(msg_a, 1'b1, 35);
      check_val("t.no_early_ov", 64'(ov_cnt), 64'(ov_mark));
      check_fields("t", msg_a, 1'b0);
      close_msg("t");
      check_val("t.ov_once", 64'(ov_cnt - ov_mark), 64'd1);

      // consumer stalls for 10 cycles while the next sof beat waits
      out_ready = 1'b0;
      drop_mark = drop_cnt;
      send_msg(msg_a, 1'b0, 35);
      check_fields("h", msg_a, 1'b0);
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_data  = msg_b.pid;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check_val("h.in_ready", 64'(in_ready),  64'd0);
         check_val("h.ov_held",  64'(out_valid), 64'd1);
         check_val("h.bprice",   64'(bid_price), 64'(msg_a.bprice));
         check_val("h.osize",    64'(offer_size), 64'(msg_a.osize));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("h.ov_clr",  64'(out_valid), 64'd0);
      check_val("h.rdy_ret", 64'(in_ready),  64'd1);
      send_msg(msg_b, 1'b0, 35);
      check_fields("b", msg_b, 1'b0);
      close_msg("b");
      check_val("b.no_drop", 64'(drop_cnt - drop_mark), 64'd0);

      // wrong category is dropped right after byte 1
      ov_mark = ov_cnt;
      drop_mark = drop_cnt;
      send_byte(8'h41, 1'b1);
      send_byte(8'h61, 1'b0);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check_val("cat.drop", 64'(drop_pulse), 64'd1);
      @(posedge clk);
      #1;
      check_val("cat.drop_1cyc", 64'(drop_pulse), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check_val("cat.no_ov", 64'(ov_cnt - ov_mark), 64'd0);
      check_val("cat.drop_cnt", 64'(drop_cnt - drop_mark), 64'd1);
      send_msg(msg_b, 1'b0, 35);
      check_fields("cat.next", msg_b, 1'b0);
      close_msg("cat.next");

      // sof re-asserted at byte 20 restarts with the new message
      ov_mark = ov_cnt;
      drop_mark = drop_cnt;
      send_msg(msg_a, 1'b0, 20);
      check_val("sof.no_drop_yet", 64'(drop_cnt - drop_mark), 64'd0);
      send_msg(msg_c, 1'b0, 35);
      check_fields("sof", msg_c, 1'b0);
      close_msg("sof");
      check_val("sof.drop_cnt", 64'(drop_cnt - drop_mark), 64'd1);
      check_val("sof.ov_once", 64'(ov_cnt - ov_mark), 64'd1);

      // reserved byte 9 nonzero flags rsvd_err but still delivers
      send_msg(msg_d, 1'b0, 35);
      check_fields("r9", msg_d, 1'b1);
      close_msg("r9");

      // reserved byte 3 nonzero
      msg_d = msg_c;
      msg_d.rsv3 = 8'h10;
      send_msg(msg_d, 1'b0, 35);
      check_fields("r3", msg_d, 1'b1);
      close_msg("r3");

      // reset in the middle of a message discards it silently
      ov_mark = ov_cnt;
      drop_mark = drop_cnt;
      send_msg(msg_b, 1'b0, 17);
      rst_n = 1'b0;
      #1;
      check_val("mrst.in_ready",  64'(in_ready),   64'd0);
      check_val("mrst.out_valid", 64'(out_valid),  64'd0);
      check_val("mrst.drop",      64'(drop_pulse), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_val("mrst.no_ov",   64'(ov_cnt - ov_mark),     64'd0);
      check_val("mrst.no_drop", 64'(drop_cnt - drop_mark), 64'd0);
      check_val("mrst.in_ready_back", 64'(in_ready), 64'd1);
      send_msg(msg_c, 1'b0, 35);
      check_fields("mrst.next", msg_c, 1'b0);
      close_msg("mrst.next");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
